// File: rtl/uart_tx_wb.sv
// Wishbone-programmable 8N1 UART transmitter with a small TX FIFO.
// Register side effects commit on the same edge that raises the one-cycle ack.
module uart_tx_wb #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd4166
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ser_tx,
  output logic        irq
);
  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [4:0]       level;
  logic             ovf, en, irqen;
  logic [15:0]      clkdiv;
  logic [15:0]      div_lat, div_nxt, bit_cnt, cnt_nxt;
  logic [2:0]       bit_idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             pop, push, acc, full, empty, busy, bit_done, tx_nxt;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:16]};

  assign full     = (level == DEPTH_L);
  assign empty    = (level == 5'd0);
  assign busy     = (state != IDLE);
  assign bit_done = (bit_cnt == div_lat);
  // A hit is consumed only while ack is low, so a held strobe is acked every other cycle.
  assign acc  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
  assign push = acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0] & ~full;

  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[3:2])
      2'd1:    rd_data = {16'd0, clkdiv};
      2'd2:    rd_data = {23'd0, level, ovf, empty, full, busy};
      2'd3:    rd_data = {30'd0, irqen, en};
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    div_nxt   = div_lat;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_mem[rd_ptr];
          div_nxt   = clkdiv;
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cnt_nxt = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_nxt   = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 idx_nxt   = bit_idx + 3'd1;
        end else begin
          cnt_nxt = bit_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_nxt = '0;
          // Back-to-back frames: reload straight into START with no idle bit.
          if (en && !empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_mem[rd_ptr];
            div_nxt   = clkdiv;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = bit_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_nxt = (state_nxt == START) ? 1'b0 :
                  (state_nxt == DATA)  ? shift_nxt[0] : 1'b1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      ser_tx    <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      clkdiv    <= DEFAULT_DIV;
      en        <= 1'b1;
      irqen     <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq       <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      bit_idx   <= idx_nxt;
      ser_tx    <= tx_nxt;
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rd_data : 32'd0;
      irq       <= irqen & empty & ~busy;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {4'd0, push} - {4'd0, pop};
      if (acc && wbs_we_i) begin
        case (wbs_adr_i[3:2])
          2'd0: if (wbs_sel_i[0] && full) ovf <= 1'b1;
          2'd1: clkdiv <= wbs_dat_i[15:0];
          2'd2: if (wbs_dat_i[3]) ovf <= 1'b0;
          2'd3: begin
            en    <= wbs_dat_i[0];
            irqen <= wbs_dat_i[1];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    shift   <= shift_nxt;
    div_lat <= div_nxt;
    if (push) fifo_mem[wr_ptr] <= wbs_dat_i[7:0];
  end
endmodule

// File: tb/tb_uart_tx_wb.sv
// Bench for uart_tx_wb: queue-based frame model checked every cycle, plus
// directed scenarios with hand-derived expectations and a randomized phase.
`timescale 1ns/1ps
module tb_uart_tx_wb;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack, tx, irq;
  logic [31:0] dout;

  always #5 clk = ~clk;

  uart_tx_wb #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd4166)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack),
    .wbs_dat_o(dout), .ser_tx(tx), .irq(irq));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register file, byte queue and the frame currently on the line.
  logic [7:0]  m_q[$];
  bit          m_valid = 0, m_ovf, m_en, m_irqen, m_active, m_ack, m_irq;
  int          m_div, m_per, m_t;
  logic [9:0]  m_frame;
  logic [31:0] m_dat;

  always @(posedge clk) begin : model
    logic [31:0] rv;
    bit hit, emp, ful, frame_end;
    logic [7:0] b;
    if (rst) begin
      m_valid = 1; m_q.delete(); m_ovf = 0; m_en = 1; m_irqen = 0;
      m_active = 0; m_ack = 0; m_irq = 0; m_div = 4166; m_dat = 0; m_t = 0; m_per = 1;
    end else if (m_valid) begin
      emp = (m_q.size() == 0);
      ful = (m_q.size() == DEPTH);
      hit = cyc && stb && (adr[31:4] == BASE[31:4]) && !m_ack;
      case (adr[3:2])
        2'd1:    rv = 32'(m_div);
        2'd2:    rv = 32'(m_q.size() * 16 + (m_ovf ? 8 : 0) + (emp ? 4 : 0) + (ful ? 2 : 0) + (m_active ? 1 : 0));
        2'd3:    rv = 32'((m_irqen ? 2 : 0) + (m_en ? 1 : 0));
        default: rv = 0;
      endcase
      m_irq = m_irqen && emp && !m_active;
      frame_end = m_active && (m_t == 10 * m_per - 1);
      if (m_active && !frame_end) m_t++;
      else if (m_en && !emp) begin
        b = m_q.pop_front();
        m_frame = {1'b1, b, 1'b0};
        m_per = m_div + 1; m_t = 0; m_active = 1;
      end else m_active = 0;
      if (hit && we) begin
        case (adr[3:2])
          2'd0: if (sel[0]) begin
            if (ful) m_ovf = 1;
            else m_q.push_back(dat[7:0]);
          end
          2'd1: m_div = int'(dat[15:0]);
          2'd2: if (dat[3]) m_ovf = 0;
          default: begin m_en = dat[0]; m_irqen = dat[1]; end
        endcase
      end
      m_dat = (hit && !we) ? rv : 32'd0;
      m_ack = hit;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ser_tx", {31'd0, tx}, {31'd0, m_active ? m_frame[m_t / m_per] : 1'b1});
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      chk("ack", {31'd0, ack}, {31'd0, m_ack});
      chk("dat_o", dout, m_dat);
    end
  end

  task automatic xfer(input bit w, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
    bit got = 0;
    r = '0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; sel = s; adr = BASE | {28'd0, a}; dat = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1; r = dout; end
    end
    cyc = 0; stb = 0; we = 0;
    chk("ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, a, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, a, 32'd0, 4'hF, r);
    chk(nm, r, exp);
  endtask

  task automatic wait_idle(input string nm, input bit need_empty);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      done = !m_active && (!need_empty || m_q.size() == 0);
    end
    chk(nm, {31'd0, done}, 32'd1);
  endtask

  task automatic count_low(input string nm, input int n);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk(nm, 32'(lows), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a5_bits;
    logic [31:0] rr;
    int acks;
    a5_bits = 10'b1101001010;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_ser_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_clkdiv", 4'h4, 32'd4166);
    rd_chk("rst_status", 4'h8, 32'h004);
    rd_chk("rst_ctrl", 4'hC, 32'h1);

    // Single byte at CLKDIV=3: 10 bits, 4 cycles each.
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hA5);
    @(negedge clk);
    chk("a5_pre_idle", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("a5_bit", {31'd0, tx}, {31'd0, a5_bits[i / 4]});
    end
    @(negedge clk);
    chk("a5_post_idle", {31'd0, tx}, 32'd1);
    rd_chk("a5_status", 4'h8, 32'h004);

    // Overflow: one popped, four queued, one dropped.
    wr(4'h4, 32'd15);
    for (int b = 1; b <= 6; b++) wr(4'h0, 32'(b));
    rd_chk("ovf_status", 4'h8, 32'h04B);
    wr(4'h8, 32'h8);
    rd_chk("ovf_cleared", 4'h8, 32'h043);
    wait_idle("ovf_drain", 1'b1);

    // Enable gating.
    wr(4'hC, 32'h0);
    wr(4'h0, 32'h55);
    wr(4'h0, 32'hAA);
    rd_chk("en0_status", 4'h8, 32'h020);
    count_low("en0_line_idle", 100);
    wr(4'hC, 32'h1);
    repeat (50) @(posedge clk);
    wr(4'hC, 32'h0);
    wait_idle("en_frame_done", 1'b0);
    rd_chk("en_kept", 4'h8, 32'h010);
    wr(4'hC, 32'h1);
    wait_idle("en_drain", 1'b1);

    // Interrupt.
    wr(4'hC, 32'h3);
    repeat (3) @(negedge clk);
    chk("irq_idle_high", {31'd0, irq}, 32'd1);
    wr(4'h0, 32'h3C);
    repeat (2) @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    wait_idle("irq_drain", 1'b1);
    repeat (2) @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    wr(4'hC, 32'h1);

    // Miss is never acked; a held hit is acked only every other cycle.
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = BASE + 32'h10;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (ack) acks++; end
    chk("miss_no_ack", 32'(acks), 32'd0);
    adr = BASE | 32'hC;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (ack) acks++; end
    chk("held_hit_acks", 32'(acks), 32'd2);
    cyc = 0; stb = 0;

    // Randomized traffic.
    wr(4'h4, 32'd2);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: xfer(1'b1, 4'h0, 32'($urandom_range(0, 255)),
                            ($urandom_range(0, 3) != 0) ? 4'hF : 4'hE, rr);
        5: wr(4'h4, 32'($urandom_range(0, 3)));
        6: wr(4'hC, 32'(($urandom_range(0, 1) << 1) | (($urandom_range(0, 3) != 0) ? 1 : 0)));
        7: xfer(1'b0, 4'h8, 32'd0, 4'hF, rr);
        8: wr(4'h8, $urandom);
        default: repeat ($urandom_range(1, 40)) @(posedge clk);
      endcase
    end
    wr(4'hC, 32'h1);
    wait_idle("rand_drain", 1'b1);

    // Reset during DATA bit 3 with a second byte queued.
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hC3);
    wr(4'h0, 32'h7E);
    repeat (16) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    chk("midrst_ser_tx", {31'd0, tx}, 32'd1);
    rst = 0;
    rd_chk("midrst_clkdiv", 4'h4, 32'd4166);
    rd_chk("midrst_status", 4'h8, 32'h004);
    count_low("midrst_no_resume", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
